// File: rtl/param_seq_multiplier.sv
// -----------------------------------------------------------------------------
// param_seq_multiplier
//
// Sequential shift-and-add multiplier for WIDTH-bit operands producing a
// 2*WIDTH-bit product. Operands are captured as magnitudes when start is
// accepted in IDLE. MULT then runs one add/shift iteration per cycle, and
// DONE applies the result sign and pulses done for one cycle.
//
// Signed mode treats a and b as two's complement. The most negative value
// -2^(WIDTH-1) is exact because its magnitude fits in WIDTH unsigned bits.
//
// Optional build macro:
//   SEQ_MULT_EARLY_TERM_EN - leave MULT as soon as the shifted multiplier
//                            register becomes zero. The product is unchanged;
//                            only the latency gets shorter.
//
// Reset is synchronous and active-low (reset_n).
// -----------------------------------------------------------------------------
module param_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Datapath registers
  logic [PW-1:0]    mcand_q;   // shifted multiplicand magnitude
  logic [WIDTH-1:0] mplier_q;  // shifted multiplier magnitude
  logic [PW-1:0]    acc_q;     // partial-product accumulator
  logic [CW-1:0]    cnt_q;     // iteration counter
  logic             neg_q;     // sign to apply to the final product

  // Operand conditioning applied at capture time
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             start_sign;

  // Per-iteration datapath values
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_shift;
  logic             last_iter;
  logic [PW-1:0]    product_final;

  // Convert the incoming operands to magnitudes and derive the result sign.
  always_comb begin
    a_neg = signed_mode & a[WIDTH-1];
    b_neg = signed_mode & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // A zero operand always gives +0, whatever the sign bits say.
    start_sign = (a_neg ^ b_neg) && (a != '0) && (b != '0);
  end

  // One shift-and-add step, plus the exit test for the MULT loop.
  always_comb begin
    partial      = mplier_q[0] ? mcand_q : '0;
    acc_sum      = acc_q + partial;
    mplier_shift = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_iter    = (cnt_q == LAST_CNT) || (mplier_shift == '0);
`else
    last_iter    = (cnt_q == LAST_CNT);
`endif
    product_final = neg_q ? -acc_q : acc_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples its inputs from before the clock edge.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. MULT and DONE ignore start.
  always_comb begin
    // NOTE: the default is assigned first so that no path leaves state_next
    // unassigned; otherwise a latch would be inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture in IDLE, then one add/shift iteration per MULT cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the datapath registers are cleared on reset as well, so an
      // aborted operation leaves nothing behind in them.
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= start_sign;
          end
        end
        MULT: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shift;
          cnt_q    <= cnt_q + CW'(1);
        end
        default: begin
          // DONE keeps the datapath unchanged while the result is output.
        end
      endcase
    end
  end

  // Registered result and done pulse. The product holds until the next DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        product <= product_final;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_param_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_param_seq_multiplier
//
// Self-checking bench for param_seq_multiplier. It has a WIDTH=8 instance and
// a WIDTH=16 instance. Expected products and latencies come from a reference
// model that uses plain integer arithmetic. SEQ_MULT_EARLY_TERM_EN selects the
// expected latency rule.
// -----------------------------------------------------------------------------
module tb_param_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start8, start16;
  logic        signed_mode;
  logic [15:0] a_in, b_in;

  logic [15:0] product8;
  logic        done8, busy8;
  logic [31:0] product16;
  logic        done16, busy16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start8),
    .signed_mode (signed_mode),
    .a           (a_in[7:0]),
    .b           (b_in[7:0]),
    .product     (product8),
    .done        (done8),
    .busy        (busy8)
  );

  param_seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start16),
    .signed_mode (signed_mode),
    .a           (a_in),
    .b           (b_in),
    .product     (product16),
    .done        (done16),
    .busy        (busy16)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint operand_value(bit w16, bit sm, logic [15:0] v);
    logic [7:0] v8;
    v8 = v[7:0];
    if (w16) return sm ? longint'($signed(v)) : longint'(v);
    else     return sm ? longint'($signed(v8)) : longint'(v8);
  endfunction

  function automatic logic [31:0] ref_product(bit w16, bit sm, logic [15:0] av, logic [15:0] bv);
    longint p;
    logic [31:0] p32;
    p   = operand_value(w16, sm, av) * operand_value(w16, sm, bv);
    p32 = 32'(p);
    return w16 ? p32 : {16'h0000, p32[15:0]};
  endfunction

  // Number of MULT cycles the operation should take.
  function automatic int ref_mult_cycles(bit w16, bit sm, logic [15:0] bv);
    int     width;
    longint mag;
    int     hb;
    width = w16 ? 16 : 8;
    mag   = operand_value(w16, sm, bv);
    if (mag < 0) mag = -mag;
    hb = 0;
    for (int i = 0; i < width; i++) begin
      if (((mag >> i) & 64'd1) != 0) hb = i;
    end
`ifdef SEQ_MULT_EARLY_TERM_EN
    return hb + 1;
`else
    return width + 0 * hb;
`endif
  endfunction

  function automatic logic [31:0] sel_product(bit w16);
    return w16 ? product16 : {16'h0000, product8};
  endfunction

  // ---------------------------------------------------------------------------
  // Single operation. Start is accepted at E0 and done must first be seen
  // after E(mult_cycles+1). Inputs are scrambled while the operation runs.
  // ---------------------------------------------------------------------------
  task automatic run_op(input bit w16, input bit sm, input logic [15:0] av,
                        input logic [15:0] bv, input logic [31:0] exp_p,
                        input string name);
    int          lat;
    int          seen;
    logic        d, bz;
    logic [31:0] p;
    lat  = ref_mult_cycles(w16, sm, bv);
    seen = -1;
    @(negedge clk);
    signed_mode = sm; a_in = av; b_in = bv;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    bz = w16 ? busy16 : busy8;
    checks++;
    if (bz !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, bz);
    end
    for (int k = 1; k <= lat + 6 && seen < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      d = w16 ? done16 : done8;
      if (d === 1'b1) begin
        seen = k;
      end else begin
        signed_mode = 1'($urandom);
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        if (k <= lat) begin
          if (w16) start16 = 1'($urandom); else start8 = 1'($urandom);
        end else begin
          start8 = 1'b0; start16 = 1'b0;
        end
      end
    end
    start8 = 1'b0; start16 = 1'b0;
    checks++;
    if (seen != lat + 1) begin
      errors++;
      $display("FAIL %s done_edge: got E%0d want E%0d", name, seen, lat + 1);
    end
    p = sel_product(w16);
    checks++;
    if (p !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h want %h", name, p, exp_p);
    end
    @(posedge clk);
    @(negedge clk);
    d  = w16 ? done16 : done8;
    bz = w16 ? busy16 : busy8;
    checks++;
    if (d !== 1'b0 || bz !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want done=0 busy=0", name, d, bz);
    end
    p = sel_product(w16);
    checks++;
    if (p !== exp_p) begin
      errors++;
      $display("FAIL %s product_hold: got %h want %h", name, p, exp_p);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
    signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (product8 !== 16'h0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got product=%h done=%b busy=%b want 0 0 0", product8, done8, busy8);
    end
    checks++;
    if (product16 !== 32'h0 || done16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: got product=%h done=%b busy=%b want 0 0 0", product16, done16, busy16);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, 1'b0, 16'd0,  16'd0,  32'h0000_0000, "u0x0");
    run_op(0, 1'b0, 16'd13, 16'd11, 32'h0000_008F, "u13x11");
    run_op(0, 1'b1, 16'hFD, 16'd5,  32'h0000_FFF1, "s-3x5");
    run_op(0, 1'b1, 16'h80, 16'h80, 32'h0000_4000, "s-128x-128");
    run_op(0, 1'b1, 16'd0,  16'hFB, 32'h0000_0000, "s0x-5");
    run_op(0, 1'b1, 16'hF9, 16'd0,  32'h0000_0000, "s-7x0");
    run_op(0, 1'b1, 16'h7F, 16'h80, 32'h0000_C080, "s127x-128");
    run_op(0, 1'b0, 16'd7,  16'd1,  32'h0000_0007, "u7x1");
    run_op(0, 1'b0, 16'hFF, 16'hFF, 32'h0000_FE01, "u255x255");
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    @(negedge clk);
    signed_mode = 1'b0; a_in = 16'd200; b_in = 16'd200; start8 = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;  // sampled at E4, the 4th MULT cycle
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (product8 !== 16'h0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: got product=%h done=%b busy=%b want 0 0 0", product8, done8, busy8);
    end
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_discard: got done/busy activity after reset want none");
    end
    run_op(0, 1'b0, 16'd2, 16'd3, 32'h0000_0006, "after_reset_2x3");
  endtask

  task automatic test_back_to_back();
    int          acc_e[3];
    int          done_e[3];
    int          last;
    int          edges[$];
    logic [15:0] prods[$];
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      acc_e[i]  = (i == 0) ? 0 : done_e[i-1] + 1;
      done_e[i] = acc_e[i] + ref_mult_cycles(0, 1'b0, 16'(i + 1)) + 1;
    end
    last = done_e[2] + 3;
    @(negedge clk);
    signed_mode = 1'b0; a_in = 16'd1; b_in = 16'd1; start8 = 1'b1;
    @(posedge clk);  // E0
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (k > 0 && done8 === 1'b1) begin
        edges.push_back(k);
        prods.push_back(product8);
      end
      if (k + 1 == acc_e[1]) begin
        signed_mode = 1'b0; a_in = 16'd2; b_in = 16'd2;
      end else if (k + 1 == acc_e[2]) begin
        signed_mode = 1'b0; a_in = 16'd3; b_in = 16'd3;
      end else begin
        signed_mode = 1'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
      end
      if (k >= acc_e[2]) start8 = 1'b0;
    end
    start8 = 1'b0;
    checks++;
    if (edges.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses want 3", edges.size());
    end
    for (int i = 0; i < 3; i++) begin
      exp = 16'((i + 1) * (i + 1));
      checks++;
      if (i >= edges.size()) begin
        errors++;
        $display("FAIL b2b_op%0d: got no done want E%0d product %h", i, done_e[i], exp);
      end else if (edges[i] != done_e[i] || prods[i] !== exp) begin
        errors++;
        $display("FAIL b2b_op%0d: got E%0d product %h want E%0d product %h",
                 i, edges[i], prods[i], done_e[i], exp);
      end
    end
  endtask

  task automatic test_random();
    bit          sm;
    logic [15:0] av, bv;
    for (int n = 0; n < 30; n++) begin
      sm = 1'($urandom);
      av = 16'($urandom_range(0, 255));
      bv = 16'($urandom_range(0, 255));
      if (n % 7 == 0) bv = 16'($urandom_range(0, 3));
      run_op(0, sm, av, bv, ref_product(0, sm, av, bv), "rand8");
    end
  endtask

  task automatic test_width16();
    bit          sm;
    logic [15:0] av, bv;
    run_op(1, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000, "w16_min_x_max");
    run_op(1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "w16_u_max_sq");
    for (int n = 0; n < 8; n++) begin
      sm = 1'($urandom);
      av = 16'($urandom);
      bv = 16'($urandom);
      run_op(1, sm, av, bv, ref_product(1, sm, av, bv), "rand16");
    end
  endtask

  // Watchdog so the run always ends even if the design stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port product  output  2*WIDTH  registered result; holds until next completion.
REQ-009 SHALL have port done  output  1  registered one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, MULT, DONE; IDLE->MULT on start=1 at a clock edge; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL on accepted start capture the operands as magnitudes (|a|, |b| when signed_mode=1, raw otherwise), the result sign (sign(a) XOR sign(b), signed mode only), clear the 2*WIDTH accumulator and set the iteration counter to 0.
REQ-013 SHALL in each MULT cycle add the 2*WIDTH shifted multiplicand to the accumulator when the multiplier LSB is 1, shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-014 SHALL leave MULT for DONE after the iteration at which counter equals WIDTH-1, giving exactly WIDTH MULT cycles (early termination: see REQ-022).
REQ-015 SHALL in DONE load product with the accumulator (two's-complement negated when the captured result sign is 1) and assert done for exactly the following cycle.
REQ-016 SHALL, with start sampled at edge E0, assert done and present a valid product in the cycle after edge E0+WIDTH+1.
REQ-017 SHALL ignore start, a, b and signed_mode while in MULT or DONE; an operation in flight is never aborted or restarted.
REQ-018 SHALL, with start held high continuously, accept a new operation at the first edge in IDLE, giving one result every WIDTH+2 cycles.
REQ-019 SHALL handle the most negative operand -2^(WIDTH-1) exactly in signed mode; its magnitude is held as a WIDTH-bit unsigned value and no overflow occurs in 2*WIDTH bits.
REQ-020 SHALL produce product 0 with sign forced 0 when either operand is 0 (no negative zero; negating 0 yields 0).

Reset
REQ-021 SHALL on reset_n=0 at a rising edge force state IDLE, product 0, done 0, busy 0, and clear the accumulator, counter and operand registers; any operation in flight is discarded and no done is produced for it.

Configuration
REQ-022 SHALL, when SEQ_MULT_EARLY_TERM_EN is defined, also leave MULT for DONE after any iteration whose shifted multiplier register is zero, so that latency becomes (index of the highest set bit of |b|)+1 MULT cycles, or 1 MULT cycle when b=0; the result is identical to the non-early-termination result.
REQ-023 SHALL, when SEQ_MULT_EARLY_TERM_EN is not defined, always run exactly WIDTH MULT cycles.

Verification (WIDTH=8 unless stated)
REQ-024 SHALL cover unsigned 13*11: start at E0 -> done pulse after E9, product 0x008F, busy low after E10.
REQ-025 SHALL cover signed -3*5 -> product 0xFFF1, and signed -128*-128 -> 0x4000; unsigned 255*255 -> 0xFE01.
REQ-026 SHALL cover reset_n low at the 4th MULT cycle of 200*200 -> next cycle product 0, done 0, busy 0; a following 2*3 request yields 0x0006 with normal latency.
REQ-027 SHALL cover start held high for three back-to-back ops (1*1, 2*2, 3*3) -> done pulses 10 cycles apart with products 1, 4, 9; operand changes during MULT have no effect.
REQ-028 SHALL cover unsigned 7*1 with SEQ_MULT_EARLY_TERM_EN defined -> done after E2, product 0x0007; without it -> done after E9, same product.
REQ-029 SHALL cover WIDTH=16 signed 0x8000*0x7FFF -> done after E17, product 0xC0008000.
